// File: rtl/ibuf_row_feeder.sv
// Input-buffer row feeder: streams strided SRAM rows onto the skew-stage row bus,
// then flushes the downstream pipeline with ARRAY+2 zero cycles before signalling done.
module ibuf_row_feeder #(
  parameter int DATA_WIDTH     = 8,
  parameter int ARRAY          = 32,
  parameter int MEM_DATA_WIDTH = DATA_WIDTH * ARRAY,
  parameter int ADDR_WIDTH     = 10,
  parameter int CNT_WIDTH      = 10
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      start,
  input  logic [ADDR_WIDTH-1:0]     base_addr,
  input  logic [CNT_WIDTH-1:0]      num_rows,
  input  logic [ADDR_WIDTH-1:0]     stride,
  output logic                      busy,
  output logic                      done,
  output logic                      mem_rd_req,
  output logic [ADDR_WIDTH-1:0]     mem_rd_addr,
  input  logic [MEM_DATA_WIDTH-1:0] mem_rd_data,
  output logic [MEM_DATA_WIDTH-1:0] data_out,
  output logic                      data_out_valid
);

  localparam int DRAIN_LEN = ARRAY + 2;
  localparam int DRAIN_W   = $clog2(DRAIN_LEN + 1);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_LEN - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                  state_r, state_s;
  logic [CNT_WIDTH-1:0]    row_cnt_r, row_cnt_s;
  logic [CNT_WIDTH-1:0]    num_rows_r, num_rows_s;
  logic [ADDR_WIDTH-1:0]   stride_r, stride_s;
  logic [ADDR_WIDTH-1:0]   addr_s;
  logic [DRAIN_W-1:0]      drain_cnt_r, drain_cnt_s;
  logic                    req_s;
  logic                    busy_s;
  logic                    done_s;
  logic                    rd_pending_r;

  // Next-state and next-output decode; row_cnt_r indexes the request currently on the bus.
  always_comb begin
    state_s     = state_r;
    row_cnt_s   = row_cnt_r;
    num_rows_s  = num_rows_r;
    stride_s    = stride_r;
    drain_cnt_s = drain_cnt_r;
    addr_s      = {ADDR_WIDTH{1'b0}};
    req_s       = 1'b0;

    case (state_r)
      IDLE: begin
        if (start) begin
          num_rows_s  = num_rows;
          stride_s    = stride;
          row_cnt_s   = {CNT_WIDTH{1'b0}};
          drain_cnt_s = {DRAIN_W{1'b0}};
          if (num_rows != {CNT_WIDTH{1'b0}}) begin
            state_s = READ;
            req_s   = 1'b1;
            addr_s  = base_addr;
          end else begin
            state_s = DONE;
          end
        end else begin
          state_s = IDLE;
        end
      end

      READ: begin
        if (row_cnt_r == (num_rows_r - CNT_WIDTH'(1))) begin
          state_s     = DRAIN;
          drain_cnt_s = {DRAIN_W{1'b0}};
        end else begin
          row_cnt_s = row_cnt_r + CNT_WIDTH'(1);
          req_s     = 1'b1;
          // Address arithmetic wraps modulo 2^ADDR_WIDTH by truncation.
          addr_s    = mem_rd_addr + stride_r;
        end
      end

      DRAIN: begin
        if (drain_cnt_r == DRAIN_LAST) begin
          state_s = DONE;
        end else begin
          drain_cnt_s = drain_cnt_r + DRAIN_W'(1);
        end
      end

      DONE: begin
        state_s = IDLE;
      end

      default: begin
        state_s = IDLE;
      end
    endcase

    busy_s = (state_s != IDLE);
    done_s = (state_s == DONE);
  end

  // Control state and registered command/status outputs.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r     <= IDLE;
      row_cnt_r   <= {CNT_WIDTH{1'b0}};
      num_rows_r  <= {CNT_WIDTH{1'b0}};
      stride_r    <= {ADDR_WIDTH{1'b0}};
      drain_cnt_r <= {DRAIN_W{1'b0}};
      busy        <= 1'b0;
      done        <= 1'b0;
      mem_rd_req  <= 1'b0;
      mem_rd_addr <= {ADDR_WIDTH{1'b0}};
    end else begin
      state_r     <= state_s;
      row_cnt_r   <= row_cnt_s;
      num_rows_r  <= num_rows_s;
      stride_r    <= stride_s;
      drain_cnt_r <= drain_cnt_s;
      busy        <= busy_s;
      done        <= done_s;
      mem_rd_req  <= req_s;
      mem_rd_addr <= addr_s;
    end
  end

  // Read-return pipeline: capture SRAM data one cycle after each request, zero otherwise.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_pending_r   <= 1'b0;
      data_out       <= {MEM_DATA_WIDTH{1'b0}};
      data_out_valid <= 1'b0;
    end else begin
      rd_pending_r <= mem_rd_req;
      if (rd_pending_r) begin
        data_out       <= mem_rd_data;
        data_out_valid <= 1'b1;
      end else begin
        data_out       <= {MEM_DATA_WIDTH{1'b0}};
        data_out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ibuf_row_feeder.sv
// Scoreboard bench for ibuf_row_feeder (ARRAY=4): expected requests, rows, done and busy
// windows are queued at command issue and consumed by a negedge monitor.
module tb_ibuf_row_feeder;
  localparam int DW = 8;
  localparam int AR = 4;
  localparam int MW = DW * AR;
  localparam int AW = 10;
  localparam int CW = 10;

  logic          clk = 1'b0;
  logic          resetn;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [CW-1:0] num_rows;
  logic [AW-1:0] stride;
  logic          busy;
  logic          done;
  logic          mem_rd_req;
  logic [AW-1:0] mem_rd_addr;
  logic [MW-1:0] mem_rd_data;
  logic [MW-1:0] data_out;
  logic          data_out_valid;

  always #5 clk = ~clk;

  ibuf_row_feeder #(
    .DATA_WIDTH(DW), .ARRAY(AR), .MEM_DATA_WIDTH(MW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .resetn(resetn), .start(start), .base_addr(base_addr),
    .num_rows(num_rows), .stride(stride), .busy(busy), .done(done),
    .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .data_out(data_out), .data_out_valid(data_out_valid)
  );

  function automatic logic [MW-1:0] row_of(input logic [AW-1:0] a);
    return {a, 6'h15, a, 6'h2A};
  endfunction

  // SRAM model: 1-cycle latency, random garbage when not read
  always @(posedge clk) mem_rd_data <= mem_rd_req ? row_of(mem_rd_addr) : MW'($urandom);

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  typedef struct { int cyc; logic [MW-1:0] val; } ev_t;
  typedef struct { int lo; int hi; } win_t;
  ev_t  q_req[$];
  ev_t  q_row[$];
  ev_t  q_done[$];
  win_t q_busy[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  // Cycle k after the start edge e0 is observed at the negedge where edge_cnt == e0+k-1.
  // cut >= 1 models a reset asserted during cycle cut: nothing beyond that cycle is expected.
  task automatic expect_cmd(input int e0, input logic [AW-1:0] base, input int n,
                            input logic [AW-1:0] str, input int cut);
    int kd;
    logic [AW-1:0] a;
    kd = (n == 0) ? 1 : n + AR + 3;
    for (int k = 0; k < n; k++) begin
      a = AW'(int'(base) + k * int'(str));
      if (cut < 0 || k + 1 <= cut) q_req.push_back('{e0 + k, MW'(a)});
      if (cut < 0 || k + 3 <= cut) q_row.push_back('{e0 + k + 2, row_of(a)});
    end
    if (cut < 0) q_done.push_back('{e0 + kd - 1, '0});
    q_busy.push_back('{e0, e0 + ((cut < 0) ? kd : cut) - 1});
  endtask

  task automatic issue(input logic [AW-1:0] base, input int n, input logic [AW-1:0] str,
                       input int cut);
    start     = 1'b1;
    base_addr = base;
    num_rows  = CW'(n);
    stride    = str;
    expect_cmd(edge_cnt + 1, base, n, str, cut);
    @(posedge clk); #1;
    start     = 1'b0;
    base_addr = AW'($urandom);
    num_rows  = CW'($urandom);
    stride    = AW'($urandom);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_req"}, 64'(mem_rd_req), 64'd0);
    chk({tag, "_addr"}, 64'(mem_rd_addr), 64'd0);
    chk({tag, "_data"}, 64'(data_out), 64'd0);
    chk({tag, "_valid"}, 64'(data_out_valid), 64'd0);
  endtask

  // Monitor: consume expected events whenever the DUT presents them
  always @(negedge clk) begin : mon_blk
    ev_t  ev;
    logic exp_b;
    if (edge_cnt >= 1) begin
      if (mem_rd_req) begin
        if (q_req.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_req: got addr %0h expected none (edge %0d)", mem_rd_addr, edge_cnt);
        end else begin
          ev = q_req.pop_front();
          chk("req_cycle", 64'(edge_cnt), 64'(ev.cyc));
          chk("req_addr", 64'(mem_rd_addr), 64'(ev.val));
        end
      end
      if (data_out_valid) begin
        if (q_row.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_row: got %0h expected none (edge %0d)", data_out, edge_cnt);
        end else begin
          ev = q_row.pop_front();
          chk("row_cycle", 64'(edge_cnt), 64'(ev.cyc));
          chk("row_data", 64'(data_out), 64'(ev.val));
        end
      end else begin
        chk("data_zero", 64'(data_out), 64'd0);
      end
      if (done) begin
        if (q_done.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: got 1 expected 0 (edge %0d)", edge_cnt);
        end else begin
          ev = q_done.pop_front();
          chk("done_cycle", 64'(edge_cnt), 64'(ev.cyc));
        end
      end
      exp_b = 1'b0;
      if (q_busy.size() > 0 && edge_cnt >= q_busy[0].lo && edge_cnt <= q_busy[0].hi) exp_b = 1'b1;
      chk("busy", 64'(busy), 64'(exp_b));
      if (q_busy.size() > 0 && edge_cnt >= q_busy[0].hi) void'(q_busy.pop_front());
      if (q_req.size() > 0 && q_req[0].cyc < edge_cnt) begin
        checks++; errors++;
        $display("FAIL missing_req: got none expected addr %0h at edge %0d", q_req[0].val, q_req[0].cyc);
        void'(q_req.pop_front());
      end
      if (q_row.size() > 0 && q_row[0].cyc < edge_cnt) begin
        checks++; errors++;
        $display("FAIL missing_row: got none expected %0h at edge %0d", q_row[0].val, q_row[0].cyc);
        void'(q_row.pop_front());
      end
      if (q_done.size() > 0 && q_done[0].cyc < edge_cnt) begin
        checks++; errors++;
        $display("FAIL missing_done: got none expected done at edge %0d", q_done[0].cyc);
        void'(q_done.pop_front());
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn    = 1'b0;
    start     = 1'b1;
    base_addr = 10'h123;
    num_rows  = 10'd5;
    stride    = 10'd2;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    start  = 1'b0;
    resetn = 1'b1;
    wait_cycles(1);

    // Basic stream: reqs cycles 1-3, rows 3-5, done cycle 10
    issue(10'h010, 3, 10'd1, -1);
    wait_cycles(3 + AR + 3 + 1);

    // Address wrap: 0x3FE, 0x001, 0x004
    issue(10'h3FE, 3, 10'd3, -1);
    wait_cycles(3 + AR + 3 + 1);

    // Zero rows: done and busy in cycle 1 only
    issue(10'h055, 0, 10'd7, -1);
    wait_cycles(3);

    // Ignored starts during READ and DRAIN, then back-to-back command after DONE
    issue(10'h100, 4, 10'd2, -1);
    wait_cycles(1);
    start = 1'b1; base_addr = 10'h200; num_rows = 10'd5; stride = 10'd9;
    wait_cycles(1);
    start = 1'b0;
    wait_cycles(3);
    start = 1'b1; base_addr = 10'h300; num_rows = 10'd6; stride = 10'd1;
    wait_cycles(1);
    start = 1'b0;
    wait_cycles(5);
    issue(10'h020, 2, 10'd5, -1);
    wait_cycles(2 + AR + 3 + 1);

    // Reset during cycle 4 of an 8-row command, then a fresh 2-row command
    issue(10'h040, 8, 10'd1, 4);
    wait_cycles(3);
    resetn = 1'b0;
    wait_cycles(1);
    check_all_zero("abort");
    resetn = 1'b1;
    wait_cycles(20);
    issue(10'h080, 2, 10'd1, -1);
    wait_cycles(2 + AR + 3 + 1);

    // Maximum row count
    issue(10'h000, 1023, 10'd1, -1);
    wait_cycles(1023 + AR + 3 + 1);

    wait_cycles(2);
    chk("q_req_empty", 64'(q_req.size()), 64'd0);
    chk("q_row_empty", 64'(q_row.size()), 64'd0);
    chk("q_done_empty", 64'(q_done.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
